round_key_sequencer: RTL and testbench

- Sequential round-key generator between the master-key input and the cipher round datapath.
- Latches a 128-bit master key on start and presents round keys one per handshake.
- Round 0 is the master key. Each following round applies the team's 128-bit key-schedule permutation to the previous round key.
- Replaces a fully unrolled schedule, so one permutation instance serves every round.

---
 rtl/round_key_sequencer.sv | 84 ++++++++
 tb/tb_round_key_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: latches a master key and streams ROUNDS round keys
// over a valid/ready handshake, sharing one key-schedule permutation.
module round_key_sequencer #(
  parameter int ROUNDS = 32,
  parameter int IDXW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    key_in,
  output logic            busy,
  output logic [127:0]    rk,
  output logic [IDXW-1:0] rk_idx,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(ROUNDS - 1);

  state_t state;
  logic   fire;

  // Pure bit move: rotate the low 20 bits to the top, split 36..20.
  function automatic logic [127:0] perm(input logic [127:0] k);
    return {k[19:0], k[127:36], k[20], k[35:21]};
  endfunction

  assign fire = rk_valid & rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rk     <= key_in;
            rk_idx <= '0;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          rk_valid <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (fire) begin
            if (rk_idx == LAST) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              rk     <= perm(rk);
              rk_idx <= rk_idx + 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Scoreboard bench for round_key_sequencer: expected keys queued on start,
// popped and compared on every accepted handshake.
module tb_round_key_sequencer;

  localparam int ROUNDS = 32;
  localparam int IDXW   = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [127:0]    key_in;
  logic            busy;
  logic [127:0]    rk;
  logic [IDXW-1:0] rk_idx;
  logic            rk_valid;
  logic            rk_ready;
  logic            done;

  round_key_sequencer #(
    .ROUNDS(ROUNDS),
    .IDXW  (IDXW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key_in  (key_in),
    .busy    (busy),
    .rk      (rk),
    .rk_idx  (rk_idx),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [127:0]    key;
  } exp_t;

  exp_t         q[$];
  logic [127:0] seen[ROUNDS];
  int           n_chk = 0;
  int           n_err = 0;
  int           fires = 0;
  int           dones = 0;
  int           cyc = 0;
  int           last_fire_cyc = 0;
  int           done_cyc = 0;
  int           ready_pct = 100;
  logic         stall_prev = 1'b0;
  logic [127:0] prev_rk;
  logic [IDXW-1:0] prev_idx;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference schedule written as a per-bit destination table.
  function automatic logic [127:0] model_perm(input logic [127:0] k);
    logic [127:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      if (i < 20)       d = 108 + i;
      else if (i == 20) d = 15;
      else if (i < 36)  d = i - 21;
      else              d = i - 20;
      r[d] = k[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    rk_ready = ($urandom_range(99) < ready_pct);
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_rk", rk, prev_rk);
        chk("stall_idx", 128'(rk_idx), 128'(prev_idx));
      end
      stall_prev = rk_valid && !rk_ready;
      prev_rk    = rk;
      prev_idx   = rk_idx;
      if (rk_valid && rk_ready) begin
        fires++;
        last_fire_cyc = cyc;
        if (int'(rk_idx) < ROUNDS) seen[rk_idx] = rk;
        if (q.size() == 0) begin
          chk("unexpected_fire", 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          chk("rk", rk, e.key);
          chk("rk_idx", 128'(rk_idx), 128'(e.idx));
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("q_empty_at_done", 128'(q.size()), 128'(0));
      end
    end
  end

  task automatic load(input logic [127:0] key);
    logic [127:0] k;
    exp_t e;
    k = key;
    @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = key;
    fires  = 0;
    for (int i = 0; i < ROUNDS; i++) begin
      e.idx = IDXW'(i);
      e.key = k;
      q.push_back(e);
      k = model_perm(k);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = ~key;
    @(negedge clk);
    chk("valid_in_load", 128'(rk_valid), 128'(0));
    chk("busy_in_load", 128'(busy), 128'(1));
    @(negedge clk);
    chk("valid_first", 128'(rk_valid), 128'(1));
    chk("idx_first", 128'(rk_idx), 128'(0));
  endtask

  task automatic finish_run(input string tag, input bit start_at_done);
    int n;
    int d0;
    n  = 0;
    d0 = dones;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (start_at_done) begin
      start  = 1'b1;
      key_in = {4{32'hdead_beef}};
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    chk({tag, "_done_once"}, 128'(dones - d0), 128'(1));
    chk({tag, "_fires"}, 128'(fires), 128'(ROUNDS));
    chk({tag, "_done_lat"}, 128'(done_cyc - last_fire_cyc), 128'(1));
    chk({tag, "_q_empty"}, 128'(q.size()), 128'(0));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
    chk({tag, "_idle_valid"}, 128'(rk_valid), 128'(0));
  endtask

  task automatic wait_idx(input int idx);
    int n;
    n = 0;
    while (int'(rk_idx) != idx && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idx", 128'(rk_idx), 128'(idx));
  endtask

  initial begin
    logic [127:0] kr;
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;
    #2;
    chk("rst_rk", rk, 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    #20;
    rst_n = 1'b1;

    load(128'h1);
    finish_run("s1", 1'b0);
    chk("s1_k0", seen[0], 128'h1);
    chk("s1_k1", seen[1], 128'h00001000_00000000_00000000_00000000);
    chk("s1_k2", seen[2], 128'h00000000_01000000_00000000_00000000);

    load(128'h1 << 20);
    finish_run("s2a", 1'b0);
    chk("s2a_k1", seen[1], 128'h1 << 15);
    load(128'h1 << 21);
    finish_run("s2b", 1'b0);
    chk("s2b_k1", seen[1], 128'h1);

    kr = {$urandom, $urandom, $urandom, $urandom};
    load(kr);
    finish_run("s3", 1'b0);

    ready_pct = 30;
    load(kr);
    finish_run("s4", 1'b0);
    ready_pct = 100;

    load(~kr);
    wait_idx(5);
    @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run("s5", 1'b1);

    load(kr ^ 128'h5a5a);
    wait_idx(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rk", rk, 128'(0));
    chk("arst_idx", 128'(rk_idx), 128'(0));
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    q.delete();
    d0 = dones;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 128'(dones - d0), 128'(0));
    load('1);
    finish_run("s6", 1'b0);
    chk("s6_last", seen[ROUNDS-1], '1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
